// File: rtl/clk_div_pkg.sv
// Shared helpers for the multi-channel clock divider: channel-index width and range check.
package clk_div_pkg;

  localparam int MIN_CH_W = 1;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : MIN_CH_W;
  endfunction

  function automatic logic ch_in_range(input int unsigned ch, input int unsigned num_ch);
    return ch < num_ch;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: 50% duty clock plus rising-edge tick, registered outputs, no backpressure.
// Reloads from the shadow only at ctr=1 points (boundary, park, sync), so no runt phases.
module clk_div_chan #(
  parameter int CTR_W       = 16,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CTR_W-1:0] val,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CTR_W-1:0] DEF = CTR_W'(DEFAULT_DIV);
  localparam logic [CTR_W-1:0] ONE = CTR_W'(1);

  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [CTR_W-1:0] active_q, active_d;
  logic [CTR_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  always_comb begin
    ctr_d     = ctr_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;

    if (sync || (en && (active_q == '0 || ctr_q == active_q))) begin
      ctr_d = ONE;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (sync || active_q == '0) begin
        clk_d = 1'b0;
      end else begin
        clk_d  = !clk_q;
        tick_d = !clk_q;
      end
    end else if (en) begin
      ctr_d = ctr_q + ONE;
    end

    // A write landing on a reload cycle stays pending for the next one.
    if (wr) begin
      shadow_d  = val;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ctr_q     <= ONE;
      active_q  <= DEF;
      shadow_q  <= DEF;
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH programmable clock dividers sharing one half-period write port.
// Outputs are flop-driven; writes are always accepted, with no backpressure.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int CTR_W       = 16,
  parameter  int DEFAULT_DIV = 1,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CTR_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_sel;

    // Indices past NUM_CH select no channel and are dropped.
    assign wr_sel = div_wr && ch_in_range(32'(div_ch), NUM_CH) && (32'(div_ch) == g);

    clk_div_chan #(
      .CTR_W       (CTR_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr_sel),
      .val     (div_val),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, run-time programmable clock divider; parametrised successor to the fixed single-channel divider. Each channel produces a 50 %-duty divided clock plus a one-cycle rising-edge tick. Half-period is reloadable through a write strobe, and reloads are glitch-free. Sits between the board oscillator and the timing consumers of the dispenser (servo PWM, debounce, display scan), replacing multiple fixed-ratio divider instances.

## Interface
- `NUM_CH`, 2: number of independent channels, ≥1.
- `CTR_W`, 16: half-period counter width. Maximum half-period is 2^CTR_W−1.
- `DEFAULT_DIV`, 1: half-period loaded into every channel at reset. Must be < 2^CTR_W.
- `clk_in`  input  1: sole clock. All logic is on posedge.
- `rst_n`  input  1: reset, synchronous and active-low.
- `en`  input  NUM_CH: per-channel run enable.
- `sync`  input  1: synchronous restart of all channels.
- `div_wr`  input  1: write strobe for a half-period value.
- `div_ch`  input  CH_W = max(1,$clog2(NUM_CH)): target channel of the write.
- `div_val`  input  CTR_W: new half-period in clk_in cycles. 0 parks the channel.
- `clk_out`  output  NUM_CH: divided clocks, registered.
- `tick`  output  NUM_CH: one-cycle pulse, high in the first clk_in cycle of each clk_out high phase.

## Operation
- Per-channel state: `ctr`, `active` (half-period in use), `shadow`, `pending`, `clk_out`, `tick`.
- Reset (rst_n low at a posedge):
  - ctr=1, active=shadow=DEFAULT_DIV, pending=0.
  - clk_out=0, tick=0.
  - Reset overrides every other input.
- Write: when div_wr=1 and div_ch<NUM_CH, set shadow[div_ch]=div_val and pending=1.
  - div_ch≥NUM_CH: ignored.
  - Repeated writes before a boundary: last write wins.
- Boundary: en=1, active≠0 and ctr==active.
  - clk_out toggles and ctr←1.
  - If pending, active←shadow and pending←0.
  - The new half-period applies from the next half-phase.
- Non-boundary with en=1 and active≠0: ctr←ctr+1.
- en=0: ctr, clk_out and active are frozen, tick=0, and pending waits. Writes are still accepted.
- active=0 (parked): clk_out←0, ctr←1, tick=0. A pending shadow is applied on the next posedge regardless of boundary, so a parked channel restarts within one cycle of a write.
- sync=1: for all channels, ctr←1, clk_out←0, tick=0, and active←shadow if pending.
  - sync takes priority over en, boundary and park.
  - All channels are phase-aligned on the cycle after sync.
- Write in the same cycle as a boundary or sync: the boundary or sync uses the shadow value held before the write. The write's value is left pending.
- tick←1 exactly on the posedge where clk_out goes 0→1, otherwise 0.
- Counter arithmetic is unsigned CTR_W bits. ctr never exceeds active, because reloads happen only while ctr=1.

## Timing
- Posedge 1 is the first posedge with rst_n=1.
- For half-period D, clk_out rises at posedge D and falls at posedge 2D.
- Period is 2D cycles with exactly 50 % duty. D=1 gives clk_in/2.
- tick is high for the cycle following posedges D, 3D, 5D, …
- Reload latency: a new value takes effect at the first boundary after the write cycle. Worst case is the old D cycles.
- After sync deasserts, a channel with half-period D rises D posedges later.
- Reset mid-period: output low on the next cycle. No runt pulse beyond the current cycle.
- All outputs come straight from flops. There is no combinational path from inputs to outputs.

## Structure
- Package `clk_div_pkg`:
  - `localparam` helper for CH_W.
  - Typedef for the per-channel half-period (`logic [CTR_W-1:0]` is not usable in a package, so provide a function for range checks instead).
- Sub-module `clk_div_chan`: one channel containing ctr, active, shadow, pending and outputs. Ports: clk_in, rst_n, en, sync, wr, val, clk_out, tick.
- Top `clk_div_multi`: write-address decode plus a generate loop of NUM_CH `clk_div_chan` instances.

## Test plan
- Reset, NUM_CH=2, DEFAULT_DIV=3, en=2'b11 → both clk_out rise at posedge 3 and fall at 6. tick high in the cycles after posedges 3 and 9.
- Write ch0 div_val=5 at posedge 4 (mid high phase) → fall still at 6. Next rise at 11, fall at 16. ch1 unchanged.
- Write ch1 div_val=0, then 2 → ch1 parks low after the next boundary. The second write restarts it, with the first rise 2 cycles later.
- en[0]=0 for 4 cycles mid-high-phase → clk_out[0] holds 1 and no tick. Counting resumes with the remaining count intact.
- sync pulse with channels at D=3 and D=4 in opposite phases → both low the next cycle. Rises 3 and 4 cycles after sync.
- div_ch=3 with NUM_CH=2, plus a write coinciding with a boundary → out-of-range write is ignored. The coincident value applies at the following boundary. rst_n low mid-period → all outputs 0 the next cycle.
